// File: rtl/pcileech_rst_ctl.sv
// Sequenced reset for FT601 and fabric, with button debounce and heartbeat LED.
// FT601 leaves reset first; the fabric reset follows after a settle delay.

module pcileech_rst_ctl_debounce #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(CYCLES - 1)) begin
                dout <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module pcileech_rst_ctl #(
    parameter int PARAM_POR_CYCLES      = 64,
    parameter int PARAM_SETTLE_CYCLES   = 256,
    parameter int PARAM_DEBOUNCE_CYCLES = 1000000,
    parameter int PARAM_LED_BIT         = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_rst_raw,
    input  logic       btn_inv_raw,
    output logic       sys_rst,
    output logic       ft601_rst_n,
    output logic       led_invert,
    output logic       led_heartbeat,
    output logic [7:0] rst_count
);
    localparam int CNT_MAX = (PARAM_POR_CYCLES > PARAM_SETTLE_CYCLES) ? PARAM_POR_CYCLES : PARAM_SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {S_POR, S_SETTLE, S_RUN, S_HOLD} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         btn_raw, btn_deb;
    logic               deb_rst, deb_rst_d, press;
    logic [PARAM_LED_BIT:0] hb_cnt;

    assign btn_raw = {btn_inv_raw, btn_rst_raw};

    // bit 0: reset button, bit 1: LED-invert button
    for (genvar i = 0; i < 2; i++) begin : g_db
        pcileech_rst_ctl_debounce #(.CYCLES(PARAM_DEBOUNCE_CYCLES)) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (btn_raw[i]),
            .dout (btn_deb[i])
        );
    end

    assign deb_rst    = btn_deb[0];
    assign led_invert = btn_deb[1];
    assign press      = deb_rst & ~deb_rst_d;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_POR: begin
                if (cnt == CNT_W'(PARAM_POR_CYCLES - 1)) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == CNT_W'(PARAM_SETTLE_CYCLES - 1)) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_RUN: cnt_nxt = '0;
            S_HOLD: begin
                cnt_nxt = '0;
                if (!deb_rst) state_nxt = S_POR;
            end
            default: begin
                state_nxt = S_POR;
                cnt_nxt   = '0;
            end
        endcase
        // a held button overrides any expiry on the same edge
        if (deb_rst) begin
            state_nxt = S_HOLD;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_POR;
            cnt           <= '0;
            sys_rst       <= 1'b1;
            ft601_rst_n   <= 1'b0;
            deb_rst_d     <= 1'b0;
            rst_count     <= '0;
            hb_cnt        <= '0;
            led_heartbeat <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            sys_rst       <= (state_nxt != S_RUN);
            ft601_rst_n   <= (state_nxt == S_SETTLE) || (state_nxt == S_RUN);
            deb_rst_d     <= deb_rst;
            if (press && rst_count != 8'hFF) rst_count <= rst_count + 8'd1;
            hb_cnt        <= hb_cnt + (PARAM_LED_BIT + 1)'(1);
            led_heartbeat <= hb_cnt[PARAM_LED_BIT] | deb_rst | led_invert;
        end
    end
endmodule

// File: doc/pcileech_rst_ctl.md
Name:
pcileech_rst_ctl

Overview:
- Reset and button-conditioning stage that sits directly upstream of the board top's com/fifo/pcie instances.
- Replaces the ad-hoc "tickcount < 64 | button" reset with a sequenced reset:
  - FT601 is released from reset first.
  - The fabric reset `sys_rst` is released after an FT601 settle delay.
- Also debounces the board buttons and generates the heartbeat LED.

Parameters:
- PARAM_POR_CYCLES, 64: clk cycles held in power-on reset after `rst_n` deasserts (min 1).
- PARAM_SETTLE_CYCLES, 256: clk cycles between `ft601_rst_n` release and `sys_rst` release (min 1).
- PARAM_DEBOUNCE_CYCLES, 1000000: consecutive stable synchronized samples needed to accept a button level change (10 ms @ 100 MHz; min 2).
- PARAM_LED_BIT, 26: heartbeat counter bit driving the LED.

Ports:
- clk, input, 1: 100 MHz system clock.
- rst_n, input, 1: asynchronous, active-low reset (e.g. clock-wizard locked); all state clears immediately on assertion.
- btn_rst_raw, input, 1: raw asynchronous reset button, active high.
- btn_inv_raw, input, 1: raw asynchronous LED-invert button, active high.
- sys_rst, output, 1: active-high synchronous reset to com/fifo/pcie.
- ft601_rst_n, output, 1: active-low reset to the FT601 pad.
- led_invert, output, 1: debounced `btn_inv_raw`; feeds `led_state_invert`.
- led_heartbeat, output, 1: heartbeat LED.
- rst_count, output, 8: saturating count of accepted reset-button presses.

Behaviour:
- Reset values (`rst_n` = 0), all registered outputs:
  - `sys_rst` = 1, `ft601_rst_n` = 0
  - `led_invert` = 0, `led_heartbeat` = 0, `rst_count` = 0
  - state = S_POR; all counters 0; synchronizer and debounced levels 0.
- Synchronizers: each raw button passes through a 2-flop synchronizer, reset to 0. No other logic samples raw inputs.
- Debounce, per button (independent counter):
  - Synchronized value ≠ debounced value: increment the counter.
  - Synchronized value = debounced value: clear the counter.
  - When the counter reaches PARAM_DEBOUNCE_CYCLES-1 while still differing, the debounced value takes the synchronized value on that edge and the counter clears.
  - Any shorter glitch is ignored.
- Press event: rising edge of debounced reset button, one cycle wide.
- State machine. Outputs are registered from the next state:
  - `sys_rst` = 0 only in S_RUN.
  - `ft601_rst_n` = 1 only in S_SETTLE and S_RUN.
- S_POR: counter increments each cycle.
  - Counter = PARAM_POR_CYCLES-1 → S_SETTLE, counter cleared.
  - `ft601_rst_n` rises on the PARAM_POR_CYCLES-th edge after `rst_n` deasserts.
- S_SETTLE: counter increments.
  - Counter = PARAM_SETTLE_CYCLES-1 → S_RUN.
  - `sys_rst` falls PARAM_SETTLE_CYCLES edges after `ft601_rst_n` rises.
- S_RUN: steady state.
- S_HOLD: entered from any state on the cycle the debounced reset button is 1.
  - Outputs are forced to reset values on that same edge.
  - Counter is held at 0.
  - Debounced button returns to 0 → S_POR (full sequence repeats).
- Priority: S_HOLD entry beats counter-expiry transitions occurring on the same edge.
- Button held through `rst_n` release:
  - Block goes to S_HOLD once debounce accepts the press.
  - That press counts as an event.
- `rst_count`:
  - +1 on each press event; saturates at 255.
  - Cleared only by `rst_n`.
- Heartbeat:
  - Free-running counter, PARAM_LED_BIT+1 bits, wraps to 0, runs in all states.
  - `led_heartbeat` is a register of counter[PARAM_LED_BIT] | debounced reset button | `led_invert`.
- `led_invert` = debounced invert button; no effect on reset sequencing.

Test Plan:
1. Params POR=4, SETTLE=8, DEBOUNCE=16; deassert `rst_n` at edge 0 → `ft601_rst_n` 0→1 at edge 4; `sys_rst` 1→0 at edge 12; `rst_count` stays 0.
2. In S_RUN, pulse `btn_rst_raw` high for 10 cycles, repeated 5 times with 3-cycle gaps → no reset, `rst_count` = 0. Then hold high 40 cycles → `sys_rst` = 1 and `ft601_rst_n` = 0 about 2+16 cycles after the rise; `rst_count` = 1.
   - After release plus debounce: `ft601_rst_n` rises 4 edges later and `sys_rst` falls 8 edges after that.
3. Press accepted during S_SETTLE on the same edge the settle counter expires → enters S_HOLD, never S_RUN, `sys_rst` stays 1.
4. Assert `rst_n` low mid-S_SETTLE for 1 ns, between edges → outputs go to reset values immediately, without waiting for a clock edge. After release, the full POR→SETTLE timing of scenario 1 repeats exactly.
5. 300 accepted presses → `rst_count` = 255 and holds. `btn_inv_raw` held 20 cycles → `led_invert` = 1 and `led_heartbeat` = 1, with no change to `sys_rst`.
6. PARAM_LED_BIT=3, no buttons → `led_heartbeat` toggles every 8 cycles, period 16, continuing across S_HOLD entry and exit.
